// File: rtl/writeback_queue.sv
// Write-back queue between the execute pipeline and the register file.
// Results are buffered in a small FIFO and retired one per cycle onto the
// register-file write port. A per-register busy scoreboard lets decode stall
// on pending destinations. PC (R15) updates bypass the queue on their own port.
//
// Handshake: a result is offered with in_valid and taken on a rising edge where
// in_valid and in_ready are both high. in_ready never depends on in_valid.
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_rd,
    input  logic [31:0] in_data,
    input  logic        pc_valid,
    input  logic [31:0] pc_data,
    input  logic        resv_valid,
    input  logic [3:0]  resv_rd,
    input  logic [3:0]  chk_rs,
    input  logic [3:0]  chk_rt,
    output logic        stall,
    output logic        RegWrite,
    output logic [3:0]  Rd,
    output logic [31:0] BusW,
    output logic        RegWrite2,
    output logic [31:0] BusW2,
    output logic [2:0]  count,
    output logic        err
);

    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [2:0]    FULL    = 3'(DEPTH);

    logic [3:0]    mem_rd   [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [15:0]   busy;
    logic [15:0]   busy_next;

    logic push;
    logic pop;
    logic bad_push;
    logic bad_resv;
    logic resv_set;

    // Reset gates in_ready so nothing is accepted while the block is held.
    assign in_ready = rst_n & (count < FULL) & ~flush;
    assign push     = in_valid & in_ready & (in_rd != 4'd15);
    assign bad_push = in_valid & in_ready & (in_rd == 4'd15);
    assign pop      = (count != 3'd0) & ~flush;
    assign stall    = busy[chk_rs] | busy[chk_rt] | (resv_valid & busy[resv_rd]);
    assign resv_set = resv_valid & ~stall & (resv_rd != 4'd15) & ~flush;
    assign bad_resv = resv_valid & (resv_rd == 4'd15) & ~flush;

    // Queue storage: contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr]   <= in_rd;
            mem_data[wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy; flush empties the queue outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 3'd0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Retire the head onto the register-file port; Rd/BusW hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite <= 1'b0;
            Rd       <= 4'd0;
            BusW     <= 32'd0;
        end else begin
            RegWrite <= pop;
            if (pop) begin
                Rd   <= mem_rd[rd_ptr];
                BusW <= mem_data[rd_ptr];
            end
        end
    end

    // PC bypass port and the illegal-request pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite2 <= 1'b0;
            BusW2     <= 32'd0;
            err       <= 1'b0;
        end else begin
            RegWrite2 <= pc_valid;
            BusW2     <= pc_data;
            err       <= bad_push | bad_resv;
        end
    end

    // Scoreboard next state: retiring write clears, accepted reservation sets.
    always_comb begin
        busy_next = busy;
        if (RegWrite) busy_next[Rd] = 1'b0;
        if (resv_set) busy_next[resv_rd] = 1'b1;
        busy_next[15] = 1'b0;
    end

    // Scoreboard register; R15 is never tracked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 16'd0;
        end else if (flush) begin
            busy <= 16'd0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_writeback_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rd;
  logic [31:0] in_data;
  logic        pc_valid;
  logic [31:0] pc_data;
  logic        resv_valid;
  logic [3:0]  resv_rd;
  logic [3:0]  chk_rs;
  logic [3:0]  chk_rt;
  logic        stall;
  logic        RegWrite;
  logic [3:0]  Rd;
  logic [31:0] BusW;
  logic        RegWrite2;
  logic [31:0] BusW2;
  logic [2:0]  count;
  logic        err;

  int n_cmp;
  int n_err;

  // reference model state
  logic [35:0] exp_q[$];
  logic [15:0] m_busy;
  logic        m_rw;
  logic [3:0]  m_rd;
  logic [31:0] m_busw;
  logic        m_rw2;
  logic [31:0] m_busw2;
  logic        m_err;

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .pc_valid(pc_valid), .pc_data(pc_data),
    .resv_valid(resv_valid), .resv_rd(resv_rd), .chk_rs(chk_rs), .chk_rt(chk_rt),
    .stall(stall), .RegWrite(RegWrite), .Rd(Rd), .BusW(BusW),
    .RegWrite2(RegWrite2), .BusW2(BusW2), .count(count), .err(err)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    exp_q.delete();
    m_busy  = 16'd0;
    m_rw    = 1'b0;
    m_rd    = 4'd0;
    m_busw  = 32'd0;
    m_rw2   = 1'b0;
    m_busw2 = 32'd0;
    m_err   = 1'b0;
  endtask

  function automatic logic exp_ready();
    return (exp_q.size() < DEPTH) && !flush;
  endfunction

  function automatic logic exp_stall();
    return m_busy[chk_rs] || m_busy[chk_rt] || (resv_valid && m_busy[resv_rd]);
  endfunction

  // advance the model over one rising edge using the inputs currently applied
  task automatic model_edge();
    logic        rdy;
    logic        stl;
    logic        do_pop;
    logic        do_push;
    logic        do_set;
    logic [35:0] head;
    rdy     = exp_ready();
    stl     = exp_stall();
    do_pop  = (exp_q.size() > 0) && !flush;
    do_push = in_valid && rdy && (in_rd != 4'd15);
    do_set  = resv_valid && !stl && (resv_rd != 4'd15) && !flush;
    m_err   = (in_valid && rdy && in_rd == 4'd15) || (resv_valid && resv_rd == 4'd15 && !flush);
    if (flush) begin
      m_busy = 16'd0;
    end else begin
      if (m_rw) m_busy[m_rd] = 1'b0;
      if (do_set) m_busy[resv_rd] = 1'b1;
    end
    if (do_pop) begin
      head   = exp_q.pop_front();
      m_rw   = 1'b1;
      m_rd   = head[35:32];
      m_busw = head[31:0];
    end else begin
      m_rw = 1'b0;
    end
    if (flush) exp_q.delete();
    if (do_push) exp_q.push_back({in_rd, in_data});
    m_rw2   = pc_valid;
    m_busw2 = pc_data;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_rd      = 4'd0;
    in_data    = 32'd0;
    pc_valid   = 1'b0;
    pc_data    = 32'd0;
    resv_valid = 1'b0;
    resv_rd    = 4'd0;
    chk_rs     = 4'd0;
    chk_rt     = 4'd0;
  endtask

  // one clock: edge, model update, return at the falling edge
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (count !== 3'd0)    begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (RegWrite !== 1'b0 || RegWrite2 !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b/%b want 0/0", RegWrite, RegWrite2); end
    n_cmp++; if (Rd !== 4'd0 || BusW !== 32'd0 || BusW2 !== 32'd0) begin n_err++; $display("FAIL reset_data: got %h/%h/%h want 0", Rd, BusW, BusW2); end
    n_cmp++; if (err !== 1'b0)      begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
    chk_rs = 4'd3; chk_rt = 4'd9;
    #1;
    n_cmp++; if (stall !== 1'b0)    begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_hazard();
    int cyc;
    logic seen;
    clear_inputs();
    resv_valid = 1'b1; resv_rd = 4'd3;
    tick();
    clear_inputs();
    in_valid = 1'b1; in_rd = 4'd3; in_data = 32'hDEADBEEF; chk_rs = 4'd3;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 10) begin
      #1;
      if (RegWrite) begin
        seen = 1'b1;
        n_cmp++; if (Rd !== 4'd3 || BusW !== 32'hDEADBEEF) begin n_err++; $display("FAIL hazard_write: got Rd=%0d BusW=%h want 3/deadbeef", Rd, BusW); end
      end
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL hazard_stall_hold: cycle %0d got %b want 1", cyc, stall); end
      tick();
      in_valid = 1'b0;
      cyc++;
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL hazard_timeout: got no RegWrite want one within 10 cycles"); end
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL hazard_stall_release: got %b want 0", stall); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [35:0] order_q[$];
    logic [35:0] e;
    int pushed;
    int cyc;
    clear_inputs();
    pushed = 0;
    cyc    = 0;
    while ((pushed < 5 || order_q.size() > 0) && cyc < 25) begin
      if (pushed < 5) begin
        in_valid = 1'b1;
        in_rd    = 4'(pushed + 1);
        in_data  = $urandom;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_cmp++; if (count > 3'd4) begin n_err++; $display("FAIL b2b_count_bound: got %0d want <=4", count); end
      n_cmp++; if (in_ready !== (count != 3'd4)) begin n_err++; $display("FAIL b2b_ready: got %b with count %0d", in_ready, count); end
      if (RegWrite) begin
        if (order_q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL b2b_extra_write: got Rd=%0d want none", Rd);
        end else begin
          e = order_q.pop_front();
          n_cmp++; if ({Rd, BusW} !== e) begin n_err++; $display("FAIL b2b_order: got %0d/%h want %0d/%h", Rd, BusW, e[35:32], e[31:0]); end
        end
      end
      if (in_valid && in_ready) begin
        order_q.push_back({in_rd, in_data});
        pushed++;
      end
      tick();
      cyc++;
    end
    n_cmp++; if (pushed != 5 || order_q.size() != 0) begin n_err++; $display("FAIL b2b_timeout: got pushed=%0d pending=%0d want 5/0", pushed, order_q.size()); end
    idle(2);
  endtask

  task automatic test_r15_and_pc();
    clear_inputs();
    in_valid = 1'b1; in_rd = 4'd15; in_data = 32'h1234;
    pc_valid = 1'b1; pc_data = 32'h40;
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (err !== 1'b1)       begin n_err++; $display("FAIL r15_err_pulse: got %b want 1", err); end
    n_cmp++; if (count !== 3'd0)     begin n_err++; $display("FAIL r15_not_queued: got %0d want 0", count); end
    n_cmp++; if (RegWrite2 !== 1'b1 || BusW2 !== 32'h40) begin n_err++; $display("FAIL pc_bypass: got %b/%h want 1/40", RegWrite2, BusW2); end
    tick();
    #1;
    n_cmp++; if (err !== 1'b0)       begin n_err++; $display("FAIL r15_err_single: got %b want 0", err); end
    n_cmp++; if (RegWrite !== 1'b0)  begin n_err++; $display("FAIL r15_no_write: got %b want 0", RegWrite); end
    n_cmp++; if (RegWrite2 !== 1'b0) begin n_err++; $display("FAIL pc_drop: got %b want 0", RegWrite2); end
    resv_valid = 1'b1; resv_rd = 4'd15;
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (err !== 1'b1)       begin n_err++; $display("FAIL resv15_err: got %b want 1", err); end
    idle(2);
  endtask

  task automatic test_flush();
    clear_inputs();
    resv_valid = 1'b1; resv_rd = 4'd2;
    tick();
    resv_rd = 4'd7;
    tick();
    clear_inputs();
    in_valid = 1'b1; in_rd = 4'd9; in_data = 32'hA5A5_0001;
    tick();
    clear_inputs();
    flush = 1'b1;
    in_valid = 1'b1; in_rd = 4'd10; in_data = 32'h5555;
    resv_valid = 1'b1; resv_rd = 4'd5;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    tick();
    clear_inputs();
    chk_rs = 4'd2; chk_rt = 4'd7;
    #1;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", count); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b want 0", stall); end
    chk_rs = 4'd5; chk_rt = 4'd10;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL flush_resv_discard: got %b want 0", stall); end
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL flush_no_write: cycle %0d got %b want 0", i, RegWrite); end
      tick();
    end
    idle(1);
  endtask

  task automatic test_resv_busy();
    clear_inputs();
    resv_valid = 1'b1; resv_rd = 4'd4;
    tick();
    in_valid = 1'b1; in_rd = 4'd4; in_data = 32'h0000_0444;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL resv_busy_stall: got %b want 1", stall); end
    tick();
    clear_inputs();
    tick();
    #1;
    n_cmp++; if (RegWrite !== 1'b1 || Rd !== 4'd4) begin n_err++; $display("FAIL resv_drain: got %b/%0d want 1/4", RegWrite, Rd); end
    tick();
    resv_valid = 1'b1; resv_rd = 4'd4;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL resv_retry_stall: got %b want 0", stall); end
    tick();
    clear_inputs();
    chk_rs = 4'd4;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL resv_retry_set: got %b want 1", stall); end
    // release R4 again
    clear_inputs();
    in_valid = 1'b1; in_rd = 4'd4; in_data = 32'h0;
    tick();
    idle(3);
  endtask

  task automatic test_async_reset();
    clear_inputs();
    in_valid = 1'b1; in_rd = 4'd6; in_data = 32'h6666;
    tick();
    in_rd = 4'd8; in_data = 32'h8888;
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (RegWrite !== 1'b1 || count !== 3'd1) begin n_err++; $display("FAIL areset_setup: got %b/%0d want 1/1", RegWrite, count); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL areset_we: got %b want 0", RegWrite); end
    n_cmp++; if (count !== 3'd0)    begin n_err++; $display("FAIL areset_count: got %0d want 0", count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL areset_ready: got %b want 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (RegWrite !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL areset_no_write: cycle %0d got %b/%0d want 0/0", i, RegWrite, count); end
      tick();
    end
  endtask

  task automatic test_random();
    clear_inputs();
    for (int i = 0; i < 400; i++) begin
      flush      = ($urandom_range(0, 19) == 0);
      in_valid   = ($urandom_range(0, 1) == 1);
      in_rd      = 4'($urandom_range(0, 15));
      in_data    = $urandom;
      pc_valid   = ($urandom_range(0, 3) == 0);
      pc_data    = $urandom;
      resv_valid = ($urandom_range(0, 2) == 0);
      resv_rd    = 4'($urandom_range(0, 15));
      chk_rs     = 4'($urandom_range(0, 15));
      chk_rt     = 4'($urandom_range(0, 15));
      #1;
      n_cmp++; if (in_ready !== exp_ready()) begin n_err++; $display("FAIL rnd_ready: cyc %0d got %b want %b", i, in_ready, exp_ready()); end
      n_cmp++; if (stall !== exp_stall()) begin n_err++; $display("FAIL rnd_stall: cyc %0d got %b want %b", i, stall, exp_stall()); end
      n_cmp++; if (count !== 3'(exp_q.size())) begin n_err++; $display("FAIL rnd_count: cyc %0d got %0d want %0d", i, count, exp_q.size()); end
      n_cmp++; if (RegWrite !== m_rw) begin n_err++; $display("FAIL rnd_we: cyc %0d got %b want %b", i, RegWrite, m_rw); end
      n_cmp++; if (Rd !== m_rd || BusW !== m_busw) begin n_err++; $display("FAIL rnd_wdata: cyc %0d got %0d/%h want %0d/%h", i, Rd, BusW, m_rd, m_busw); end
      n_cmp++; if (RegWrite2 !== m_rw2 || BusW2 !== m_busw2) begin n_err++; $display("FAIL rnd_pc: cyc %0d got %b/%h want %b/%h", i, RegWrite2, BusW2, m_rw2, m_busw2); end
      n_cmp++; if (err !== m_err) begin n_err++; $display("FAIL rnd_err: cyc %0d got %b want %b", i, err, m_err); end
      tick();
    end
    clear_inputs();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_hazard();
    test_back_to_back();
    test_r15_and_pc();
    test_flush();
    test_resv_busy();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
